// File: rtl/pp_pipeline_accel_fifo_rd_axis.sv
// Purpose: drains a frame of pixels from an upstream FIFO onto an AXI4-Stream master, tagging line-end (tlast) and frame-start (tuser).
// Latency: 1 cycle from fifo_read to the beat appearing on m_axis_*; done pulses once the output buffer has drained after the last read.
// Backpressure: a 2-entry skid buffer absorbs m_axis_tready stalls; fifo_read depends only on a registered slot-free flag, never on tready.
// Optional feature: define PP_FIFO_RD_AXIS_SOF_EN to drive m_axis_tuser on the first pixel of each frame; otherwise tuser is tied low.
module pp_pipeline_accel_fifo_rd_axis #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  cols,
  input  logic [DIM_WIDTH-1:0]  rows,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty_n,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_read,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [DIM_WIDTH-1:0] DIM_ONE = {{(DIM_WIDTH-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_nxt;

  // Frame geometry captured at start, plus the position of the next pixel to read.
  logic [DIM_WIDTH-1:0] cols_r;
  logic [DIM_WIDTH-1:0] rows_r;
  logic [DIM_WIDTH-1:0] col_cnt;
  logic [DIM_WIDTH-1:0] row_cnt;

  // Two-entry output buffer, written at wr_ptr and presented from rd_ptr.
  logic [DATA_WIDTH-1:0] buf_dat [2];
  logic [1:0]            buf_last;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            buf_cnt;

  logic slot_free;
  logic push;
  logic pop;
  logic at_col_end;
  logic at_row_end;
  logic last_pix;
  logic first_pix;

  assign slot_free  = (buf_cnt != 2'd2);
  assign at_col_end = (col_cnt == (cols_r - DIM_ONE));
  assign at_row_end = (row_cnt == (rows_r - DIM_ONE));
  assign last_pix   = at_col_end & at_row_end;
  assign first_pix  = (col_cnt == '0) & (row_cnt == '0);

  // Pop the FIFO whenever a frame is running, data is there and the buffer can take it.
  assign fifo_read = (state == RUN) & fifo_empty_n & slot_free;
  assign push      = fifo_read;
  assign pop       = m_axis_tvalid & m_axis_tready;

  // Outputs are zeroed whenever the buffer is empty so stale entries never leak out.
  assign m_axis_tvalid = (buf_cnt != 2'd0);
  assign m_axis_tdata  = m_axis_tvalid ? buf_dat[rd_ptr] : '0;
  assign m_axis_tlast  = m_axis_tvalid & buf_last[rd_ptr];

`ifdef PP_FIFO_RD_AXIS_SOF_EN
  logic [1:0] buf_user;

  assign m_axis_tuser = m_axis_tvalid & buf_user[rd_ptr];

  // Frame-start flag travels alongside each buffered beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_user <= '0;
    end else if (push) begin
      buf_user[wr_ptr] <= first_pix;
    end
  end
`else
  assign m_axis_tuser = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; done fires in FLUSH once nothing is left in the buffer.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if ((cols == '0) || (rows == '0)) begin
            state_nxt = FLUSH;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (fifo_read && last_pix) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (buf_cnt == 2'd0) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // busy falls in the same cycle done is raised.
  assign busy = (state != IDLE) & ~done;

  // Geometry latch and column/row position counters; start outside IDLE is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      cols_r  <= '0;
      rows_r  <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      cols_r  <= cols;
      rows_r  <= rows;
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (fifo_read) begin
      if (at_col_end) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + DIM_ONE;
      end else begin
        col_cnt <= col_cnt + DIM_ONE;
      end
    end
  end

  // Buffer storage: capture FIFO head on read, tagging line-end.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_dat[i] <= '0;
      end
      buf_last <= '0;
    end else if (push) begin
      buf_dat[wr_ptr]  <= fifo_dout;
      buf_last[wr_ptr] <= at_col_end;
    end
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      buf_cnt <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_rd_axis.sv
// Bench for pp_pipeline_accel_fifo_rd_axis: emulated upstream FIFO, expected-beat scoreboard built from frame geometry.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Handles both builds of the optional frame-start flag.
module tb_pp_pipeline_accel_fifo_rd_axis;

`ifdef PP_FIFO_RD_AXIS_SOF_EN
  localparam bit SOF = 1'b1;
`else
  localparam bit SOF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cols = '0;
  logic [15:0] rows = '0;
  logic        busy;
  logic        done;
  logic        fifo_empty_n = 1'b0;
  logic [7:0]  fifo_dout = '0;
  logic        fifo_read;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        m_axis_tuser;

  pp_pipeline_accel_fifo_rd_axis #(.DATA_WIDTH(8), .DIM_WIDTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cols          (cols),
    .rows          (rows),
    .busy          (busy),
    .done          (done),
    .fifo_empty_n  (fifo_empty_n),
    .fifo_dout     (fifo_dout),
    .fifo_read     (fifo_read),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  logic [7:0] fq[$];
  beat_t      exp_q[$];

  int  passed = 0;
  int  total  = 0;
  int  fails  = 0;
  int  reads  = 0;
  int  beats  = 0;
  int  done_cnt = 0;
  bit  gap_on = 1'b0;
  bit  pop_pend = 1'b0;
  bit  stall_prev = 1'b0;
  logic [7:0] held_d;
  logic       held_l;
  logic       held_u;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty_n = (fq.size() > 0) && !gap_on;
    fifo_dout    = (fq.size() > 0) ? fq[0] : 8'h00;
  endtask

  // One clock: sample and score on the falling edge, then apply the FIFO pop after the rising edge.
  task automatic cycle();
    beat_t e;
    @(negedge clk);
    if (done) begin
      done_cnt++;
      chk("busy_low_at_done", busy, 0);
      chk("all_beats_out_before_done", exp_q.size(), 0);
    end
    if (gap_on) chk("no_read_in_gap", fifo_read, 0);
    if (fifo_read) begin
      chk("read_only_when_data", fq.size() > 0, 1);
      pop_pend = 1'b1;
      reads++;
    end
    if (stall_prev) begin
      chk("valid_held_in_stall", m_axis_tvalid, 1);
      chk("tdata_held_in_stall", m_axis_tdata, held_d);
      chk("tlast_held_in_stall", m_axis_tlast, held_l);
      chk("tuser_held_in_stall", m_axis_tuser, held_u);
    end
    if (m_axis_tvalid && m_axis_tready) begin
      beats++;
      chk("beat_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("beat_tdata", m_axis_tdata, e.d);
        chk("beat_tlast", m_axis_tlast, e.l);
        chk("beat_tuser", m_axis_tuser, e.u);
      end
    end
    stall_prev = m_axis_tvalid && !m_axis_tready;
    held_d = m_axis_tdata;
    held_l = m_axis_tlast;
    held_u = m_axis_tuser;
    chk("buffered_at_most_2", (reads - beats) <= 2, 1);
    @(posedge clk);
    #1;
    if (pop_pend && fq.size() > 0) void'(fq.pop_front());
    pop_pend = 1'b0;
    drive_fifo();
  endtask

  // Load a frame into the FIFO and expected list, start it, and run until done or timeout.
  // mode: 0 tready always high, 1 tready 1010..., 2 random tready. exp_lat < 0 skips the latency check.
  task automatic run_frame(input int c, input int r, input int mode, input int gap_start,
                           input bit restart, input int exp_lat);
    int k;
    int lat;
    logic [7:0] d;
    for (int i = 0; i < c * r; i++) begin
      d = 8'($urandom);
      fq.push_back(d);
      exp_q.push_back('{d, (i % c) == (c - 1), SOF && (i == 0)});
    end
    reads = 0;
    beats = 0;
    done_cnt = 0;
    stall_prev = 1'b0;
    cols = 16'(c);
    rows = 16'(r);
    start = 1'b1;
    k = 0;
    lat = -1;
    while (lat < 0 && k < 400) begin
      case (mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (k % 2) == 0;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      gap_on = (gap_start >= 0) && (k >= gap_start) && (k < gap_start + 3);
      if (restart && k == 3) begin
        start = 1'b1;
        cols  = 16'd1;
        rows  = 16'd1;
      end
      drive_fifo();
      cycle();
      start = 1'b0;
      if (done_cnt > 0) lat = k;
      k++;
    end
    gap_on = 1'b0;
    drive_fifo();
    chk("done_pulses", done_cnt, 1);
    chk("beat_count", beats, c * r);
    chk("read_count", reads, c * r);
    chk("expected_drained", exp_q.size(), 0);
    if (exp_lat >= 0) chk("start_to_done_cycles", lat, exp_lat);
    cycle();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    int k;
    drive_fifo();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fifo_read", fifo_read, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tuser", m_axis_tuser, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle();

    // 4x2 at full rate: 8 back-to-back beats, done one cycle after the last beat.
    run_frame(4, 2, 0, -1, 1'b0, 10);
    // Same frame under 1010 tready.
    run_frame(4, 2, 1, -1, 1'b0, -1);
    // Three-cycle FIFO gap mid-line delays completion by exactly three cycles.
    run_frame(4, 2, 0, 4, 1'b0, 13);
    // Empty geometry: no beats, done on the cycle after start.
    run_frame(0, 5, 0, -1, 1'b0, 1);
    run_frame(3, 0, 2, -1, 1'b0, 1);
    // A second start while busy must not change the running frame.
    run_frame(4, 2, 0, -1, 1'b1, 10);
    // Single-pixel frame: beat is both line-end and frame-start.
    run_frame(1, 1, 0, -1, 1'b0, 3);
    // Random geometry and random backpressure.
    for (int n = 0; n < 4; n++) begin
      run_frame($urandom_range(1, 6), $urandom_range(1, 4), 2, -1, 1'b0, -1);
    end
    run_frame(5, 3, 2, 6, 1'b0, -1);

    // Reset after the third beat of a 4x2 frame.
    for (int i = 0; i < 8; i++) begin
      fq.push_back(8'(i + 8'h40));
      exp_q.push_back('{8'(i + 8'h40), (i % 4) == 3, SOF && (i == 0)});
    end
    reads = 0;
    beats = 0;
    stall_prev = 1'b0;
    cols = 16'd4;
    rows = 16'd2;
    start = 1'b1;
    m_axis_tready = 1'b1;
    drive_fifo();
    k = 0;
    while (beats < 3 && k < 50) begin
      cycle();
      start = 1'b0;
      k++;
    end
    chk("beats_before_reset", beats, 3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("post_reset_tvalid", m_axis_tvalid, 0);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_fifo_read", fifo_read, 0);
    fq.delete();
    exp_q.delete();
    stall_prev = 1'b0;
    drive_fifo();
    cycle();
    run_frame(4, 2, 0, -1, 1'b0, 10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pp_pipeline_accel_fifo_rd_axis.md
PP_PIPELINE_ACCEL_FIFO_RD_AXIS -- requirements
Module: pp_pipeline_accel_fifo_rd_axis

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter DIM_WIDTH, default 16, width of the cols/rows fields.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle frame start request.
REQ-006 SHALL have port cols, input, DIM_WIDTH, pixels per line, sampled on accepted start.
REQ-007 SHALL have port rows, input, DIM_WIDTH, lines per frame, sampled on accepted start.
REQ-008 SHALL have port busy, output, 1, high from accepted start until done.
REQ-009 SHALL have port done, output, 1, one-cycle frame-complete pulse.
REQ-010 SHALL have port fifo_empty_n, input, 1, upstream FIFO holds data.
REQ-011 SHALL have port fifo_dout, input, DATA_WIDTH, FIFO head data, valid while fifo_empty_n=1.
REQ-012 SHALL have port fifo_read, output, 1, pops the FIFO head this cycle.
REQ-013 SHALL have port m_axis_tdata, output, DATA_WIDTH, stream data.
REQ-014 SHALL have port m_axis_tvalid, output, 1, stream valid.
REQ-015 SHALL have port m_axis_tready, input, 1, stream ready.
REQ-016 SHALL have port m_axis_tlast, output, 1, last pixel of a line.
REQ-017 SHALL have port m_axis_tuser, output, 1, first pixel of a frame.

Function
REQ-018 SHALL implement FSM IDLE -> RUN -> FLUSH -> IDLE.
REQ-019 In IDLE, start=1 SHALL latch cols/rows, zero the column/row counters, and enter RUN.
REQ-020 If the latched cols=0 or rows=0, SHALL skip RUN, go straight to FLUSH, and emit no beats.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 fifo_read SHALL equal (state==RUN) & fifo_empty_n & (output buffer has a free slot); it SHALL be combinational.
REQ-023 fifo_dout SHALL be captured on the same cycle fifo_read=1, so the beat is presented no earlier than the next cycle (latency 1).
REQ-024 The output stage SHALL be a 2-entry skid buffer: one beat per cycle while m_axis_tready=1, no bubbles, no combinational path from m_axis_tready to fifo_read beyond the slot-free term.
REQ-025 tdata/tlast/tuser SHALL stay stable while tvalid=1 and tready=0.
REQ-026 The column counter SHALL increment per FIFO read and wrap to 0 at cols-1; the row counter SHALL increment on that wrap.
REQ-027 tlast SHALL be set on the beat read at column cols-1; tuser on the beat read at row 0, column 0.
REQ-028 After the read at (rows-1, cols-1), SHALL enter FLUSH and issue no further fifo_read.
REQ-029 FLUSH SHALL wait until the buffer is empty, then pulse done for 1 cycle, drop busy in that same cycle, and return to IDLE.
REQ-030 Counters SHALL be DIM_WIDTH bits; the maximum frame is (2^DIM_WIDTH-1)^2 pixels, with no overflow.

Reset
REQ-031 reset=1 SHALL force IDLE and clear the buffer and counters, giving busy=0, done=0, fifo_read=0, tvalid=0, tlast=0, tuser=0, tdata=0.
REQ-032 reset mid-frame SHALL discard buffered beats; FIFO contents are not touched.

Configuration
REQ-033 With macro PP_FIFO_RD_AXIS_SOF_EN defined, tuser SHALL behave per REQ-027.
REQ-034 Without PP_FIFO_RD_AXIS_SOF_EN, m_axis_tuser SHALL be tied 0 and its flag storage SHALL be removed; the port list is unchanged.

Verification
REQ-035 cols=4, rows=2, FIFO preloaded 0x00..0x07, tready=1: 8 beats on consecutive cycles with data 0..7, tlast on beats 3 and 7, tuser on beat 0, done 1 cycle after beat 7.
REQ-036 Same frame with tready toggling 1010...: data order 0..7 intact, tdata held while stalled, fifo_read never lets more than 2 beats be buffered.
REQ-037 fifo_empty_n low for 3 cycles mid-line: fifo_read=0 during the gap, tvalid drops after the buffer drains, and the column count resumes correctly.
REQ-038 start with cols=0, rows=5: zero beats, zero fifo_read, done pulse and busy=0 within 2 cycles.
REQ-039 reset after beat 2 of a 4x2 frame: next cycle tvalid=0 and busy=0; a new start then gives tuser on the first beat.
REQ-040 Second start during busy: ignored; the frame completes with the original cols/rows.
